// File: rtl/nand_page_buffer_pkg.sv
// Shared types and constants for the NAND page buffer: read-during-write modes,
// erase-sweep FSM states and the NAND erased-word value.
package nand_buf_pkg;

    typedef enum {WRITE_FIRST, READ_FIRST, NO_CHANGE} rd_mode_e;

    typedef enum logic {SWEEP, READY} buf_state_e;

    localparam logic [7:0] NAND_ERASED_BYTE = 8'hFF;

endpackage

// File: rtl/nand_page_buffer_if.sv
// Access bus of the page buffer: port A (NAND sequencer), port B (host/ECC), erase control
// and status.
interface nand_page_buffer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
);
    logic              clr;
    logic              clk_en_a;
    logic              clk_en_b;
    logic              we_a;
    logic              we_b;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic              vld_a;
    logic              vld_b;
    logic              busy;
    logic              coll;

    modport master (
        output clr, clk_en_a, clk_en_b, we_a, we_b, addr_a, addr_b, data_a, data_b,
        input  out_a, out_b, vld_a, vld_b, busy, coll
    );

    modport slave (
        input  clr, clk_en_a, clk_en_b, we_a, we_b, addr_a, addr_b, data_a, data_b,
        output out_a, out_b, vld_a, vld_b, busy, coll
    );

endinterface

// File: rtl/nand_buf_sweep.sv
// Erase-sweep controller: walks every word address once after reset or a clear request,
// holding the buffer busy until the last word has been written.
module nand_buf_sweep
    import nand_buf_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    output logic              o_busy,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr
);

    localparam logic [ADDR_W:0] LAST_PTR = {1'b0, {ADDR_W{1'b1}}};

    buf_state_e      r_state;
    logic [ADDR_W:0] r_ptr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= SWEEP;
            r_ptr   <= '0;
        end else if (i_clr) begin
            r_state <= SWEEP;
            r_ptr   <= '0;
        end else if (r_state == SWEEP) begin
            if (r_ptr == LAST_PTR) begin
                r_state <= READY;
                r_ptr   <= '0;
            end else begin
                r_ptr <= r_ptr + (ADDR_W + 1)'(1);
            end
        end
    end

    assign o_busy = (r_state == SWEEP);
    assign o_we   = (r_state == SWEEP);
    assign o_addr = r_ptr[ADDR_W-1:0];

endmodule

// File: rtl/nand_page_buffer.sv
// True dual-port page buffer with erase sweep, per-port read-during-write mode,
// optional output register and write-write collision flag.
module nand_page_buffer
    import nand_buf_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 11,
    parameter rd_mode_e          RD_MODE  = WRITE_FIRST,
    parameter int                OUT_REG  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(NAND_ERASED_BYTE)
) (
    input logic               clk,
    input logic               reset,
    nand_page_buffer_if.slave bus
);

    localparam int DEPTH      = 2 ** ADDR_W;
    localparam bit HOLD_ON_WR = (RD_MODE == NO_CHANGE);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_busy;
    logic              w_sweep_we;
    logic [ADDR_W-1:0] w_sweep_addr;

    nand_buf_sweep #(
        .ADDR_W (ADDR_W)
    ) u_sweep (
        .i_clk  (clk),
        .i_rst  (reset),
        .i_clr  (bus.clr),
        .o_busy (w_busy),
        .o_we   (w_sweep_we),
        .o_addr (w_sweep_addr)
    );

    logic              w_acc_a;
    logic              w_acc_b;
    logic              w_wr_a;
    logic              w_wr_b;
    logic              w_coll;
    logic              w_mem_we_a;
    logic [ADDR_W-1:0] w_mem_addr_a;
    logic [DATA_W-1:0] w_mem_din_a;

    assign w_acc_a = bus.clk_en_a && !w_busy && !bus.clr;
    assign w_acc_b = bus.clk_en_b && !w_busy && !bus.clr;
    assign w_wr_a  = w_acc_a && bus.we_a;
    assign w_coll  = w_wr_a && w_acc_b && bus.we_b && (bus.addr_a == bus.addr_b);
    // Port A wins a same-address write, so port B's store is suppressed.
    assign w_wr_b  = w_acc_b && bus.we_b && !w_coll;

    assign w_mem_we_a   = w_sweep_we || w_wr_a;
    assign w_mem_addr_a = w_sweep_we ? w_sweep_addr : bus.addr_a;
    assign w_mem_din_a  = w_sweep_we ? INIT_VAL : bus.data_a;

    always_ff @(posedge clk) begin
        if (w_mem_we_a) r_mem[w_mem_addr_a] <= w_mem_din_a;
    end

    always_ff @(posedge clk) begin
        if (w_wr_b) r_mem[bus.addr_b] <= bus.data_b;
    end

    logic [DATA_W-1:0] r_q1_a;
    logic [DATA_W-1:0] r_q1_b;
    logic              r_v1_a;
    logic              r_v1_b;
    logic              r_coll1;

    // Array reads here see pre-edge contents, giving old data to a cross-port reader.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q1_a  <= '0;
            r_q1_b  <= '0;
            r_v1_a  <= 1'b0;
            r_v1_b  <= 1'b0;
            r_coll1 <= 1'b0;
        end else begin
            r_v1_a  <= w_acc_a && !(bus.we_a && HOLD_ON_WR);
            r_v1_b  <= w_acc_b && !(bus.we_b && HOLD_ON_WR);
            r_coll1 <= w_coll;
            if (w_acc_a) begin
                if (!bus.we_a || RD_MODE == READ_FIRST) r_q1_a <= r_mem[bus.addr_a];
                else if (RD_MODE == WRITE_FIRST)        r_q1_a <= bus.data_a;
            end
            if (w_acc_b) begin
                if (!bus.we_b || RD_MODE == READ_FIRST) r_q1_b <= r_mem[bus.addr_b];
                else if (RD_MODE == WRITE_FIRST)        r_q1_b <= bus.data_b;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] r_q2_a;
            logic [DATA_W-1:0] r_q2_b;
            logic              r_v2_a;
            logic              r_v2_b;
            logic              r_coll2;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q2_a  <= '0;
                    r_q2_b  <= '0;
                    r_v2_a  <= 1'b0;
                    r_v2_b  <= 1'b0;
                    r_coll2 <= 1'b0;
                end else begin
                    r_v2_a  <= r_v1_a;
                    r_v2_b  <= r_v1_b;
                    r_coll2 <= r_coll1;
                    if (r_v1_a) r_q2_a <= r_q1_a;
                    if (r_v1_b) r_q2_b <= r_q1_b;
                end
            end

            assign bus.out_a = r_q2_a;
            assign bus.out_b = r_q2_b;
            assign bus.vld_a = r_v2_a;
            assign bus.vld_b = r_v2_b;
            assign bus.coll  = r_coll2;
        end else begin : g_no_out_reg
            assign bus.out_a = r_q1_a;
            assign bus.out_b = r_q1_b;
            assign bus.vld_a = r_v1_a;
            assign bus.vld_b = r_v1_b;
            assign bus.coll  = r_coll1;
        end
    endgenerate

    assign bus.busy = w_busy;

endmodule

// File: tb/tb_nand_page_buffer.sv
// Drives one stimulus stream into three buffers (WRITE_FIRST/0, READ_FIRST/0, NO_CHANGE/OUT_REG=1)
// and scores every valid output against per-instance expectation queues.
module tb_nand_page_buffer;
    import nand_buf_pkg::*;

    logic       clk = 1'b0;
    logic [2:0] rst = 3'b111;
    logic       clr = 1'b0, en_a = 1'b0, en_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
    logic [3:0] addr_a = '0, addr_b = '0;
    logic [7:0] data_a = '0, data_b = '0;

    logic [7:0] out_a_v [3];
    logic [7:0] out_b_v [3];
    logic       vld_a_v [3];
    logic       vld_b_v [3];
    logic       busy_v  [3];
    logic       coll_v  [3];

    logic [7:0] exp_a [3][$];
    logic [7:0] exp_b [3][$];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nand_page_buffer_if #(.DATA_W(8), .ADDR_W(4)) bus [3] ();

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].clr      = clr;
        assign bus[g].clk_en_a = en_a;
        assign bus[g].clk_en_b = en_b;
        assign bus[g].we_a     = we_a;
        assign bus[g].we_b     = we_b;
        assign bus[g].addr_a   = addr_a;
        assign bus[g].addr_b   = addr_b;
        assign bus[g].data_a   = data_a;
        assign bus[g].data_b   = data_b;
        assign out_a_v[g]      = bus[g].out_a;
        assign out_b_v[g]      = bus[g].out_b;
        assign vld_a_v[g]      = bus[g].vld_a;
        assign vld_b_v[g]      = bus[g].vld_b;
        assign busy_v[g]       = bus[g].busy;
        assign coll_v[g]       = bus[g].coll;

        nand_page_buffer #(
            .DATA_W   (8),
            .ADDR_W   (4),
            .RD_MODE  (rd_mode_e'(g)),
            .OUT_REG  ((g == 2) ? 1 : 0),
            .INIT_VAL (8'hFF)
        ) u_dut (
            .clk   (clk),
            .reset (rst[g]),
            .bus   (bus[g])
        );

        always @(negedge clk) begin
            if (vld_a_v[g]) begin
                if (exp_a[g].size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected vld_a dut%0d: got %h expected none", g, out_a_v[g]);
                end else begin
                    check($sformatf("out_a dut%0d", g), out_a_v[g], exp_a[g].pop_front());
                end
            end
            if (vld_b_v[g]) begin
                if (exp_b[g].size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected vld_b dut%0d: got %h expected none", g, out_b_v[g]);
                end else begin
                    check($sformatf("out_b dut%0d", g), out_b_v[g], exp_b[g].pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 1'b0; en_a = 1'b0; en_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    endtask

    task automatic acc_a(input logic we, input logic [3:0] a, input logic [7:0] d);
        en_a = 1'b1; we_a = we; addr_a = a; data_a = d;
    endtask

    task automatic acc_b(input logic we, input logic [3:0] a, input logic [7:0] d);
        en_b = 1'b1; we_b = we; addr_b = a; data_b = d;
    endtask

    // A read returns the stored word on every instance.
    task automatic exp_rd(input bit port_b, input logic [7:0] d);
        for (int g = 0; g < 3; g++) begin
            if (port_b) exp_b[g].push_back(d);
            else        exp_a[g].push_back(d);
        end
    endtask

    // A write returns new data (WRITE_FIRST), old data (READ_FIRST), nothing (NO_CHANGE).
    task automatic exp_wr(input bit port_b, input logic [7:0] nw, input logic [7:0] old);
        if (port_b) begin
            exp_b[0].push_back(nw);
            exp_b[1].push_back(old);
        end else begin
            exp_a[0].push_back(nw);
            exp_a[1].push_back(old);
        end
    endtask

    task automatic check_busy_window(input string tag);
        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < 3; g++) check($sformatf("%s busy dut%0d e%0d", tag, g, i), 8'(busy_v[g]), 8'd1);
            step();
        end
        for (int g = 0; g < 3; g++) check($sformatf("%s busy done dut%0d", tag, g), 8'(busy_v[g]), 8'd0);
    endtask

    initial begin
        step();
        step();
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst out_a dut%0d", g), out_a_v[g], 8'h00);
            check($sformatf("rst out_b dut%0d", g), out_b_v[g], 8'h00);
            check($sformatf("rst vld dut%0d", g), {6'd0, vld_a_v[g], vld_b_v[g]}, 8'd0);
            check($sformatf("rst coll dut%0d", g), 8'(coll_v[g]), 8'd0);
            check($sformatf("rst busy dut%0d", g), 8'(busy_v[g]), 8'd1);
        end
        rst = 3'b000;
        check_busy_window("init");

        // Erased contents on port A
        for (int i = 0; i < 16; i++) begin
            acc_a(1'b0, 4'(i), 8'h00);
            exp_rd(1'b0, 8'hFF);
            step();
        end
        idle();

        // Write then cross-port read
        acc_a(1'b1, 4'd3, 8'h5A); exp_wr(1'b0, 8'h5A, 8'hFF); step(); idle();
        acc_b(1'b0, 4'd3, 8'h00); exp_rd(1'b1, 8'h5A); step(); idle();

        // Read-during-write modes on addr 7
        acc_a(1'b1, 4'd7, 8'h11); exp_wr(1'b0, 8'h11, 8'hFF); step();
        acc_a(1'b1, 4'd7, 8'h22); exp_wr(1'b0, 8'h22, 8'h11); step(); idle();
        step(); step();
        check("nochange out_a hold", out_a_v[2], 8'hFF);
        check("nochange vld_a", 8'(vld_a_v[2]), 8'd0);
        acc_a(1'b0, 4'd7, 8'h00); exp_rd(1'b0, 8'h22); step(); idle();

        // Same-address collision
        acc_a(1'b1, 4'd9, 8'hAA); acc_b(1'b1, 4'd9, 8'hBB);
        exp_wr(1'b0, 8'hAA, 8'hFF); exp_wr(1'b1, 8'hBB, 8'hFF);
        step(); idle();
        check("coll dut0 e0", 8'(coll_v[0]), 8'd1);
        check("coll dut1 e0", 8'(coll_v[1]), 8'd1);
        check("coll dut2 e0", 8'(coll_v[2]), 8'd0);
        step();
        check("coll dut0 e1", 8'(coll_v[0]), 8'd0);
        check("coll dut2 e1", 8'(coll_v[2]), 8'd1);
        step();
        check("coll dut2 e2", 8'(coll_v[2]), 8'd0);
        acc_a(1'b0, 4'd9, 8'h00); exp_rd(1'b0, 8'hAA); step(); idle();
        acc_a(1'b1, 4'd9, 8'hCC); acc_b(1'b0, 4'd9, 8'h00);
        exp_wr(1'b0, 8'hCC, 8'hAA); exp_rd(1'b1, 8'hAA); step(); idle();
        acc_b(1'b0, 4'd9, 8'h00); exp_rd(1'b1, 8'hCC); step(); idle();

        // Different-address simultaneous writes
        acc_a(1'b1, 4'd10, 8'h01); acc_b(1'b1, 4'd11, 8'h02);
        exp_wr(1'b0, 8'h01, 8'hFF); exp_wr(1'b1, 8'h02, 8'hFF);
        step(); idle();
        for (int g = 0; g < 3; g++) check($sformatf("nocoll dut%0d e0", g), 8'(coll_v[g]), 8'd0);
        step();
        for (int g = 0; g < 3; g++) check($sformatf("nocoll dut%0d e1", g), 8'(coll_v[g]), 8'd0);
        acc_a(1'b0, 4'd10, 8'h00); acc_b(1'b0, 4'd11, 8'h00);
        exp_rd(1'b0, 8'h01); exp_rd(1'b1, 8'h02); step(); idle();

        // Pipelined back-to-back reads on B
        for (int i = 0; i < 3; i++) begin
            acc_a(1'b1, 4'(i), 8'h30 + 8'(i)); exp_wr(1'b0, 8'h30 + 8'(i), 8'hFF); step();
        end
        idle(); step(); step();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                acc_b(1'b0, 4'(i), 8'h00); exp_rd(1'b1, 8'h30 + 8'(i));
            end else begin
                idle();
            end
            step();
            check($sformatf("pipe vld_b dut2 e%0d", i), 8'(vld_b_v[2]), (i >= 1 && i <= 3) ? 8'd1 : 8'd0);
            check($sformatf("pipe vld_b dut0 e%0d", i), 8'(vld_b_v[0]), (i <= 2) ? 8'd1 : 8'd0);
            if (i >= 1 && i <= 3) check($sformatf("pipe out_b dut2 e%0d", i), out_b_v[2], 8'h30 + 8'(i - 1));
        end

        // Clear while ready (access dropped), then clear again at sweep ptr 5
        clr = 1'b1; acc_a(1'b1, 4'd3, 8'h77); step(); idle();
        for (int g = 0; g < 3; g++) check($sformatf("clr busy dut%0d", g), 8'(busy_v[g]), 8'd1);
        repeat (5) step();
        clr = 1'b1; step(); clr = 1'b0;
        check_busy_window("clr");
        acc_a(1'b0, 4'd3, 8'h00); exp_rd(1'b0, 8'hFF); step(); idle();
        acc_a(1'b0, 4'd1, 8'h00); exp_rd(1'b0, 8'hFF); step(); idle();

        // Async reset of the pipelined instance with reads in flight
        acc_b(1'b0, 4'd5, 8'h00); exp_b[0].push_back(8'hFF); exp_b[1].push_back(8'hFF); step();
        acc_b(1'b0, 4'd6, 8'h00); exp_b[0].push_back(8'hFF); exp_b[1].push_back(8'hFF); step();
        idle();
        check("pre-reset vld_b dut2", 8'(vld_b_v[2]), 8'd1);
        rst[2] = 1'b1;
        #1;
        check("async rst vld_b dut2", 8'(vld_b_v[2]), 8'd0);
        check("async rst out_b dut2", out_b_v[2], 8'h00);
        check("async rst busy dut2", 8'(busy_v[2]), 8'd1);
        step(); step();
        rst[2] = 1'b0;
        repeat (20) step();
        check("post-reset busy dut2", 8'(busy_v[2]), 8'd0);
        check("post-reset vld_b dut2", 8'(vld_b_v[2]), 8'd0);

        repeat (3) step();
        for (int g = 0; g < 3; g++) begin
            check($sformatf("drain exp_a dut%0d", g), 8'(exp_a[g].size()), 8'd0);
            check($sformatf("drain exp_b dut%0d", g), 8'(exp_b[g].size()), 8'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
